memdata_param: RTL and testbench

- Parametrised successor to the pipeline CPU's data memory.
- Single-port synchronous RAM with configurable width and depth, per-byte write enables, and a registered read with valid strobe.
- After reset it runs an optional clear sweep, and an out-of-range access flag.
- Sits in the MEM stage. The pipeline stalls on ready=0 and captures load data on rvalid.

---
 rtl/memdata_param.sv | 124 ++++++++++++
 tb/tb_memdata_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/memdata_param.sv
// Single-port data RAM for the MEM stage: byte-masked writes, 1-cycle
// registered read with rvalid, optional post-reset clear sweep, and an
// out-of-range error pulse.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   req, we          access request (taken when ready=1), 1=write 0=read
//   byte_en          per-byte write mask, bit i covers data_in[8i+7:8i]
//   address          word address
//   data_in          write data
//   data_out         registered read data, changes only with rvalid
//   rvalid           read accepted last cycle has its data on data_out
//   ready            request accepted this cycle
//   err              access accepted last cycle had address >= DEPTH
module memdata_param #(
  parameter int    DATA_WIDTH     = 16,
  parameter int    ADDR_WIDTH     = 9,
  parameter int    DEPTH          = 512,
  parameter string INIT_FILE      = "",
  parameter bit    CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rvalid,
  output logic                    ready,
  output logic                    err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    rvalid_q, err_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic in_range;
  logic acc;
  logic wr_acc;
  logic rd_acc;
  logic clr_we;

  assign in_range = ({1'b0, address} < DEPTH_W);
  assign ready    = (state_q == RUN) && !reset;
  assign acc      = req && ready;
  assign wr_acc   = acc && we && in_range;
  assign rd_acc   = acc && !we;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == LAST) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Out-of-range reads return zero rather than aliasing.
  always_comb begin
    dout_d = dout_q;
    if (rd_acc) begin
      dout_d = in_range ? mem[address] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_ptr_q <= '0;
      dout_q    <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      dout_q    <= dout_d;
      rvalid_q  <= rd_acc;
      err_q     <= acc && !in_range;
    end
  end

  // Storage has no reset so contents survive when no sweep is configured.
  always_ff @(posedge clk) begin
    if (clr_we && !reset) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (byte_en[b]) begin
          mem[address][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  assign data_out = dout_q;
  assign rvalid   = rvalid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_memdata_param.sv
// Randomized bench for memdata_param against an array reference model.
// Main DUT: DEPTH=300 with clear sweep; second DUT: DEPTH=512, no sweep.
module tb_memdata_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        req_nc = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [8:0]  addr = '0;
  logic [15:0] din = '0;

  logic [15:0] dout, dout_n;
  logic        rv, rv_n, er, er_n, rdy, rdy_n;

  int total = 0;
  int bad = 0;

  logic [15:0] mdl [512];
  logic [15:0] exp_dout;

  always #5 clk = ~clk;

  memdata_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(9), .DEPTH(300),
    .INIT_FILE(""), .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we),
    .byte_en(be), .address(addr), .data_in(din),
    .data_out(dout), .rvalid(rv), .ready(rdy), .err(er)
  );

  memdata_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(9), .DEPTH(512),
    .INIT_FILE(""), .CLEAR_ON_RESET(1'b0)
  ) u_nc (
    .clk(clk), .reset(reset), .req(req_nc), .we(we),
    .byte_en(be), .address(addr), .data_in(din),
    .data_out(dout_n), .rvalid(rv_n), .ready(rdy_n), .err(er_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input bit w, input logic [8:0] a,
                       input logic [15:0] d, input logic [1:0] e);
    bit oor;
    chk("ready", rdy, 1);
    req = 1'b1; we = w; addr = a; din = d; be = e;
    oor = (int'(a) >= 300);
    if (!w) begin
      exp_dout = oor ? 16'h0 : mdl[a];
    end else if (!oor) begin
      for (int b = 0; b < 2; b++)
        if (e[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
    end
    cyc();
    chk("rvalid", rv, !w);
    chk("err", er, oor);
    chk("dout", dout, exp_dout);
  endtask

  task automatic idle();
    req = 1'b0;
    cyc();
    chk("idle_rvalid", rv, 0);
    chk("idle_err", er, 0);
    chk("idle_hold", dout, exp_dout);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; req = 1'b0; req_nc = 1'b0;
    repeat (n) begin
      cyc();
      chk("rst_rvalid", rv, 0);
      chk("rst_err", er, 0);
      chk("rst_dout", dout, 0);
      chk("rst_ready", rdy, 0);
      chk("rst_ready_nc", rdy_n, 0);
    end
    reset = 1'b0;
    #1;
    chk("clear_ready", rdy, 0);
    chk("nc_ready_first", rdy_n, 1);
    for (int i = 0; i < 512; i++) mdl[i] = 16'h0;
    exp_dout = 16'h0;
  endtask

  task automatic sweep();
    int cnt = 0;
    while (rdy == 1'b0 && cnt < 2000) begin
      req = 1'($urandom);
      we = 1'($urandom);
      addr = 9'($urandom);
      din = 16'($urandom);
      be = 2'b11;
      cnt++;
      cyc();
      chk("clr_rvalid", rv, 0);
      chk("clr_err", er, 0);
    end
    req = 1'b0;
    chk("sweep_len", cnt, 300);
  endtask

  task automatic rand_ops(input int n);
    logic [8:0] a;
    repeat (n) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        if ($urandom_range(0, 7) == 0) a = 9'($urandom_range(300, 511));
        else a = 9'($urandom_range(0, 299));
        do_op(1'($urandom), a, 16'($urandom), 2'($urandom));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mdl[i] = 16'h0;
    exp_dout = 16'h0;

    do_reset(3);
    sweep();

    do_op(0, 9'h000, 16'h0, 2'b00);
    do_op(0, 9'h0FF, 16'h0, 2'b00);
    do_op(0, 9'd299, 16'h0, 2'b00);
    do_op(0, 9'h1FF, 16'h0, 2'b00);

    do_op(1, 9'h010, 16'hABCD, 2'b11);
    do_op(1, 9'h010, 16'h1234, 2'b01);
    do_op(0, 9'h010, 16'h0, 2'b00);
    chk("be_merge", dout, 16'hAB34);

    do_op(1, 9'h020, 16'h5A5A, 2'b11);
    do_op(0, 9'h020, 16'h0, 2'b00);
    chk("raw", dout, 16'h5A5A);
    do_op(0, 9'h020, 16'h0, 2'b00);
    do_op(0, 9'h010, 16'h0, 2'b00);
    do_op(0, 9'h020, 16'h0, 2'b00);

    do_op(1, 9'h010, 16'hFFFF, 2'b00);
    do_op(0, 9'h010, 16'h0, 2'b00);

    do_op(1, 9'd44, 16'h4444, 2'b11);
    do_op(1, 9'd300, 16'hFFFF, 2'b11);
    do_op(0, 9'd300, 16'h0, 2'b00);
    chk("oor_rd", dout, 16'h0);
    do_op(0, 9'd44, 16'h0, 2'b00);
    chk("no_alias", dout, 16'h4444);
    idle();
    idle();

    req_nc = 1'b1; we = 1'b1; addr = 9'h003;
    din = 16'h0F0F; be = 2'b11;
    cyc();
    chk("nc_wr_rvalid", rv_n, 0);
    we = 1'b0;
    cyc();
    chk("nc_rvalid", rv_n, 1);
    chk("nc_dout", dout_n, 16'h0F0F);
    chk("nc_err", er_n, 0);
    req_nc = 1'b0;
    cyc();
    chk("nc_rvalid_end", rv_n, 0);

    rand_ops(400);

    do_op(1, 9'h005, 16'hBEEF, 2'b11);
    do_reset(2);
    repeat (100) begin
      chk("sweep_ready", rdy, 0);
      cyc();
    end
    do_reset(2);
    sweep();
    do_op(0, 9'h005, 16'h0, 2'b00);
    chk("clr_005", dout, 16'h0);

    req_nc = 1'b1; we = 1'b0; addr = 9'h003;
    cyc();
    req_nc = 1'b0;
    chk("nc_keep_rv", rv_n, 1);
    chk("nc_keep", dout_n, 16'h0F0F);

    rand_ops(150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
